aes_seed_sequencer: RTL and testbench

- Stimulus stage directly upstream of the AES encoder/decoder pipelines in the emulation testbench.
- Accepts one seed (128-bit plaintext plus 256-bit key) over a valid/ready handshake.
- Expands each seed into 2*NUM_FLIPS+1 test vectors, issued one per accepted cycle:
  - single-bit plaintext flips with the true key,
  - the same flips with the bitwise-inverted key,
  - the unmodified seed.
- Replaces the blocking seeded loop in the transactor with a stallable, synthesizable FSM.

---
 rtl/aes_seed_sequencer_pkg.sv | 26 ++
 rtl/aes_key_slicer.sv | 21 ++
 rtl/aes_seed_sequencer.sv | 168 ++++++++++++++++
 tb/tb_aes_seed_sequencer.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_seed_sequencer_pkg.sv
// Shared AES stimulus definitions: state/key types, key byte counts and the
// seed sequencer state encoding.
package aes_seed_sequencer_pkg;

  localparam int KEY_BYTES_128 = 16;
  localparam int KEY_BYTES_192 = 24;
  localparam int KEY_BYTES_256 = 32;

  typedef logic [127:0]                 state_t;
  typedef logic [8*KEY_BYTES_128-1:0]   key128_t;
  typedef logic [8*KEY_BYTES_192-1:0]   key192_t;
  typedef logic [8*KEY_BYTES_256-1:0]   key256_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FLIP     = 2'd1,
    FLIP_INV = 2'd2,
    FINAL    = 2'd3
  } seq_state_t;

  // Single-bit plaintext mask; bit 0 is the LSB of byte 15.
  function automatic state_t flipMask(input logic [6:0] bitIdx);
    return 128'd1 << bitIdx;
  endfunction

endpackage

// File: rtl/aes_key_slicer.sv
// Cuts a 256-bit key into its 128/192/256-bit leading-byte slices, optionally
// bit-inverted.
module aes_key_slicer
  import aes_seed_sequencer_pkg::*;
(
  input  key256_t key,
  input  logic    invert,
  output key128_t key128,
  output key192_t key192,
  output key256_t key256
);

  key256_t keyEff;

  // Byte 0 is most significant, so every slice comes from the top of the key.
  assign keyEff = key ^ {256{invert}};
  assign key128 = keyEff[255 -: 128];
  assign key192 = keyEff[255 -: 192];
  assign key256 = keyEff;

endmodule

// File: rtl/aes_seed_sequencer.sv
// Expands one accepted seed into flipped-plaintext test vectors (true key,
// inverted key, then the unmodified seed) behind a stallable valid/ready port.
module aes_seed_sequencer
  import aes_seed_sequencer_pkg::*;
#(
  parameter int NUM_FLIPS        = 128,
  parameter int INCLUDE_INVERTED = 1
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           flush,
  input  logic           seedValid,
  output logic           seedReady,
  input  logic [127:0]   seedPlain,
  input  logic [255:0]   seedKey,
  output logic           outValid,
  input  logic           outReady,
  output logic [127:0]   outPlain,
  output logic [127:0]   outKey128,
  output logic [191:0]   outKey192,
  output logic [255:0]   outKey256,
  output logic [8:0]     outIndex,
  output logic           outLast,
  output logic [15:0]    seedsDone
);

  localparam logic [6:0] LAST_BIT    = 7'(NUM_FLIPS - 1);
  localparam logic [8:0] INV_BASE    = 9'(NUM_FLIPS);
  localparam logic [8:0] FINAL_INDEX = 9'((INCLUDE_INVERTED != 0) ? 2*NUM_FLIPS : NUM_FLIPS);

  seq_state_t stateR;
  logic [6:0] bitR;
  state_t     plainR;
  key256_t    keyR;

  key256_t keySrc;
  key128_t trueKey128, invKey128;
  key192_t trueKey192, invKey192;
  key256_t trueKey256, invKey256;
  logic    seedFire;
  logic    vecFire;

  assign seedFire = seedValid & seedReady;
  assign vecFire  = outValid & outReady;
  // The captured key is not registered yet on the accepting edge.
  assign keySrc   = (stateR == IDLE) ? seedKey : keyR;

  aes_key_slicer trueSlicer (
    .key(keySrc), .invert(1'b0),
    .key128(trueKey128), .key192(trueKey192), .key256(trueKey256)
  );

  aes_key_slicer invSlicer (
    .key(keySrc), .invert(1'b1),
    .key128(invKey128), .key192(invKey192), .key256(invKey256)
  );

  // Sequencer FSM; every output is registered from the next vector's contents.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stateR    <= IDLE;
      bitR      <= 7'd0;
      plainR    <= 128'd0;
      keyR      <= 256'd0;
      seedReady <= 1'b0;
      outValid  <= 1'b0;
      outPlain  <= 128'd0;
      outKey128 <= 128'd0;
      outKey192 <= 192'd0;
      outKey256 <= 256'd0;
      outIndex  <= 9'd0;
      outLast   <= 1'b0;
      seedsDone <= 16'd0;
    end else if (flush) begin
      stateR    <= IDLE;
      seedReady <= 1'b1;
      outValid  <= 1'b0;
      outPlain  <= 128'd0;
      outKey128 <= 128'd0;
      outKey192 <= 192'd0;
      outKey256 <= 256'd0;
      outIndex  <= 9'd0;
      outLast   <= 1'b0;
    end else begin
      case (stateR)
        IDLE: begin
          seedReady <= 1'b1;
          if (seedFire) begin
            plainR    <= seedPlain;
            keyR      <= seedKey;
            bitR      <= 7'd0;
            stateR    <= FLIP;
            seedReady <= 1'b0;
            outValid  <= 1'b1;
            outPlain  <= seedPlain ^ flipMask(7'd0);
            outKey128 <= trueKey128;
            outKey192 <= trueKey192;
            outKey256 <= trueKey256;
            outIndex  <= 9'd0;
            outLast   <= 1'b0;
          end
        end
        FLIP: begin
          if (vecFire) begin
            if (bitR == LAST_BIT) begin
              bitR <= 7'd0;
              if (INCLUDE_INVERTED != 0) begin
                stateR    <= FLIP_INV;
                outPlain  <= plainR ^ flipMask(7'd0);
                outKey128 <= invKey128;
                outKey192 <= invKey192;
                outKey256 <= invKey256;
                outIndex  <= INV_BASE;
              end else begin
                stateR    <= FINAL;
                outPlain  <= plainR;
                outIndex  <= FINAL_INDEX;
                outLast   <= 1'b1;
              end
            end else begin
              bitR     <= bitR + 7'd1;
              outPlain <= plainR ^ flipMask(bitR + 7'd1);
              outIndex <= 9'(bitR) + 9'd1;
            end
          end
        end
        FLIP_INV: begin
          if (vecFire) begin
            if (bitR == LAST_BIT) begin
              bitR      <= 7'd0;
              stateR    <= FINAL;
              outPlain  <= plainR;
              outKey128 <= trueKey128;
              outKey192 <= trueKey192;
              outKey256 <= trueKey256;
              outIndex  <= FINAL_INDEX;
              outLast   <= 1'b1;
            end else begin
              bitR     <= bitR + 7'd1;
              outPlain <= plainR ^ flipMask(bitR + 7'd1);
              outIndex <= INV_BASE + 9'(bitR) + 9'd1;
            end
          end
        end
        FINAL: begin
          if (vecFire) begin
            stateR    <= IDLE;
            seedReady <= 1'b1;
            outValid  <= 1'b0;
            outPlain  <= 128'd0;
            outKey128 <= 128'd0;
            outKey192 <= 192'd0;
            outKey256 <= 256'd0;
            outIndex  <= 9'd0;
            outLast   <= 1'b0;
            seedsDone <= seedsDone + 16'd1;
          end
        end
        default: begin
          stateR    <= IDLE;
          seedReady <= 1'b0;
          outValid  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_seed_sequencer.sv
// Scoreboard bench: expected vectors are queued when a seed is accepted and
// popped on every vector transfer.
module tb_aes_seed_sequencer;

  typedef struct packed {
    logic [127:0] plain;
    logic [127:0] k128;
    logic [191:0] k192;
    logic [255:0] k256;
    logic [8:0]   idx;
    logic         last;
  } vec_t;

  logic clock = 1'b0;
  logic reset = 1'b1;

  logic         flush = 1'b0, seedValid = 1'b0, outReady = 1'b0;
  logic [127:0] seedPlain = 128'd0;
  logic [255:0] seedKey = 256'd0;
  logic         seedReady, outValid, outLast;
  logic [127:0] outPlain, outKey128;
  logic [191:0] outKey192;
  logic [255:0] outKey256;
  logic [8:0]   outIndex;
  logic [15:0]  seedsDone;

  logic         flushB = 1'b0, seedValidB = 1'b0, outReadyB = 1'b1;
  logic [127:0] seedPlainB = 128'd0;
  logic [255:0] seedKeyB = 256'd0;
  logic         seedReadyB, outValidB, outLastB;
  logic [127:0] outPlainB, outKey128B;
  logic [191:0] outKey192B;
  logic [255:0] outKey256B;
  logic [8:0]   outIndexB;
  logic [15:0]  seedsDoneB;

  aes_seed_sequencer dut (
    .clock(clock), .reset(reset), .flush(flush),
    .seedValid(seedValid), .seedReady(seedReady), .seedPlain(seedPlain), .seedKey(seedKey),
    .outValid(outValid), .outReady(outReady), .outPlain(outPlain),
    .outKey128(outKey128), .outKey192(outKey192), .outKey256(outKey256),
    .outIndex(outIndex), .outLast(outLast), .seedsDone(seedsDone)
  );

  aes_seed_sequencer #(.NUM_FLIPS(4), .INCLUDE_INVERTED(0)) dutB (
    .clock(clock), .reset(reset), .flush(flushB),
    .seedValid(seedValidB), .seedReady(seedReadyB), .seedPlain(seedPlainB), .seedKey(seedKeyB),
    .outValid(outValidB), .outReady(outReadyB), .outPlain(outPlainB),
    .outKey128(outKey128B), .outKey192(outKey192B), .outKey256(outKey256B),
    .outIndex(outIndexB), .outLast(outLastB), .seedsDone(seedsDoneB)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int   checks = 0, passes = 0;
  vec_t expQ[$];
  vec_t expQB[$];
  int   stepCnt = 0, accepts = 0, acceptStep = 0;
  int   firstXferStep = 0, lastXferStep = 0, busyViol = 0;
  int   readyMode = 0;
  bit   directedOn = 1'b0, stallPrev = 1'b0;
  vec_t held;
  logic [15:0] expDone = 16'd0;
  logic [3:0]  readyPat = 4'b1001;

  task automatic chk(input string tag, input logic [$bits(vec_t)-1:0] obs, input logic [$bits(vec_t)-1:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic vec_t mkVec(input logic [127:0] p, input logic [255:0] k, input bit inv,
                                 input int idx, input bit last);
    logic [255:0] kk;
    kk = inv ? ~k : k;
    return {p, kk[255:128], kk[255:64], kk, 9'(idx), last};
  endfunction

  task automatic pushSeed(input logic [127:0] p, input logic [255:0] k, input int nf,
                          input bit inv, input bit toB);
    vec_t v;
    for (int i = 0; i < nf; i++) begin
      v = mkVec(p ^ (128'd1 << i), k, 1'b0, i, 1'b0);
      if (toB) expQB.push_back(v); else expQ.push_back(v);
    end
    if (inv) begin
      for (int i = 0; i < nf; i++) begin
        v = mkVec(p ^ (128'd1 << i), k, 1'b1, nf + i, 1'b0);
        if (toB) expQB.push_back(v); else expQ.push_back(v);
      end
    end
    v = mkVec(p, k, 1'b0, inv ? 2*nf : nf, 1'b1);
    if (toB) expQB.push_back(v); else expQ.push_back(v);
  endtask

  // One cycle of the main instance, entered and left just after a falling edge.
  task automatic stepA();
    vec_t obs, e;
    if (readyMode == 0) outReady = 1'b1;
    else if (readyMode == 1) outReady = readyPat[stepCnt % 4];
    obs = {outPlain, outKey128, outKey192, outKey256, outIndex, outLast};
    if (stallPrev) chk("stall_hold", {obs, outValid}, {held, 1'b1});
    stallPrev = outValid && !outReady && !flush;
    held = obs;
    if (seedReady && outValid) busyViol++;
    if (outValid && outReady && !flush) begin
      if (expQ.size() == 0) chk("scoreboard_depth", expQ.size(), 1);
      else begin
        e = expQ.pop_front();
        chk("vector", obs, e);
        if (directedOn) begin
          case (e.idx)
            9'd0:    chk("idx0_plain", outPlain, 128'd1);
            9'd127:  chk("idx127_plain", outPlain, {1'b1, 127'd0});
            9'd128:  chk("idx128_key128", outKey128, 128'hFFFEFDFCFBFAF9F8F7F6F5F4F3F2F1F0);
            9'd256:  chk("idx256_final", {outPlain, outLast}, {128'd0, 1'b1});
            default: ;
          endcase
        end
        if (outIndex == 9'd0) firstXferStep = stepCnt;
        if (outLast) begin
          lastXferStep = stepCnt;
          expDone = expDone + 16'd1;
        end
      end
    end
    if (seedValid && seedReady && !flush) begin
      pushSeed(seedPlain, seedKey, 128, 1'b1, 1'b0);
      accepts++;
      acceptStep = stepCnt;
    end
    @(posedge clock);
    @(negedge clock);
    stepCnt++;
  endtask

  task automatic sendSeedA(input logic [127:0] p, input logic [255:0] k);
    int a0, n;
    a0 = accepts;
    n = 0;
    seedPlain = p;
    seedKey = k;
    seedValid = 1'b1;
    while (accepts == a0 && n < 10) begin stepA(); n++; end
    seedValid = 1'b0;
    chk("seed_accept", accepts, a0 + 1);
  endtask

  task automatic drainA(input int budget);
    int n;
    n = 0;
    while (expQ.size() > 0 && n < budget) begin stepA(); n++; end
    chk("drain", expQ.size(), 0);
  endtask

  task automatic waitIndexA(input int idx);
    int n;
    n = 0;
    while (!(outValid && outIndex == 9'(idx)) && n < 400) begin stepA(); n++; end
    chk("reach_index", {outValid, outIndex}, {1'b1, 9'(idx)});
  endtask

  logic [255:0] ramp;
  logic [127:0] bExp [5];
  int           nB;
  bit           bAcc;

  initial begin
    for (int b = 0; b < 32; b++) ramp[255 - 8*b -: 8] = 8'(b);

    // Reset state
    repeat (2) @(negedge clock);
    chk("reset_outputs", {outValid, seedReady, outLast, outIndex, seedsDone, outPlain},
        {1'b0, 1'b0, 1'b0, 9'd0, 16'd0, 128'd0});
    reset = 1'b0;
    @(negedge clock);
    chk("ready_after_reset", seedReady, 1'b1);

    // Full seed with continuous readiness
    directedOn = 1'b1;
    sendSeedA(128'd0, ramp);
    drainA(400);
    chk("consecutive_cycles", lastXferStep - firstXferStep, 256);
    chk("seeds_done_1", seedsDone, expDone);
    directedOn = 1'b0;

    // Same seed under a 1,0,0,1 ready pattern; inputs scrambled after capture
    readyMode = 1;
    sendSeedA(128'd0, ramp);
    seedPlain = {128{1'b1}};
    seedKey = {8{$urandom()}};
    drainA(1200);
    chk("seeds_done_2", seedsDone, expDone);
    readyMode = 0;

    // Back-to-back seeds with seedValid held high
    busyViol = 0;
    seedPlain = 128'h0123456789ABCDEF_FEDCBA9876543210;
    seedKey = ramp;
    seedValid = 1'b1;
    begin
      int a0, n;
      a0 = accepts;
      n = 0;
      while (accepts < a0 + 2 && n < 600) begin
        stepA();
        n++;
        if (accepts == a0 + 1) seedPlain = 128'hDEADBEEF_00000000_CAFEF00D_12345678;
      end
      seedValid = 1'b0;
      chk("b2b_accepts", accepts, a0 + 2);
    end
    chk("b2b_gap", acceptStep, lastXferStep + 1);
    drainA(400);
    chk("busy_ready", busyViol, 0);
    chk("seeds_done_3", seedsDone, expDone);

    // Flush at index 50 together with outReady
    sendSeedA(128'd0, ramp);
    waitIndexA(50);
    flush = 1'b1;
    stepA();
    flush = 1'b0;
    expQ.delete();
    stallPrev = 1'b0;
    chk("flush_valid", outValid, 1'b0);
    chk("flush_seeds_done", seedsDone, expDone);
    sendSeedA(128'h5555_0000_AAAA_0000_5555_0000_AAAA_0000, ~ramp);
    drainA(400);
    chk("post_flush_done", seedsDone, expDone);

    // Asynchronous reset mid FLIP_INV
    sendSeedA(128'd0, ramp);
    waitIndexA(200);
    #2 reset = 1'b1;
    #1;
    chk("async_reset", {outValid, seedReady, outLast, outIndex, seedsDone, outPlain, outKey256},
        {1'b0, 1'b0, 1'b0, 9'd0, 16'd0, 128'd0, 256'd0});
    expQ.delete();
    expDone = 16'd0;
    stallPrev = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    // Reduced configuration: 4 flips, no inverted pass
    bExp[0] = ~128'h1;
    bExp[1] = ~128'h2;
    bExp[2] = ~128'h4;
    bExp[3] = ~128'h8;
    bExp[4] = {128{1'b1}};
    seedPlainB = {128{1'b1}};
    seedKeyB = {8{$urandom()}};
    seedValidB = 1'b1;
    outReadyB = 1'b1;
    nB = 0;
    bAcc = 1'b0;
    for (int c = 0; c < 14; c++) begin
      if (outValidB && outReadyB) begin
        if (expQB.size() == 0) chk("b_scoreboard_depth", expQB.size(), 1);
        else begin
          chk("b_vector", {outPlainB, outKey128B, outKey192B, outKey256B, outIndexB, outLastB},
              expQB.pop_front());
          if (nB < 5) chk("b_plain", outPlainB, bExp[nB]);
          if (outLastB) chk("b_last_index", outIndexB, 9'd4);
          nB++;
        end
      end
      if (seedValidB && seedReadyB) begin
        pushSeed(seedPlainB, seedKeyB, 4, 1'b0, 1'b1);
        bAcc = 1'b1;
      end
      @(posedge clock);
      @(negedge clock);
      if (bAcc) seedValidB = 1'b0;
    end
    chk("b_vector_count", nB, 5);
    chk("b_drained", expQB.size(), 0);
    chk("b_seeds_done", seedsDoneB, 16'd1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
